msk_spook_inv_sbox_pipe: RTL and testbench

- Masked, d-share, bitsliced inverse Clyde/Spook 4-bit S-box for the decryption datapath.
- Built as a 4-stage glitch-robust pipeline of serial masked AND gadgets with valid/ready handshakes on both ends.
- Sits between the inverse L-box and the round-key addition in the masked Clyde decryption round.
- Output sharing recombines to S^-1(input recombined).

---
 rtl/msk_spook_inv_sbox_pipe_if.sv | 25 ++
 rtl/msk_spook_inv_sbox_pipe.sv | 130 +++++++++++++
 tb/tb_msk_spook_inv_sbox_pipe.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/msk_spook_inv_sbox_pipe_if.sv
// Handshake/data bundle for the masked inverse Spook S-box pipeline.
// The master drives input sharings, randomness and out_ready; the slave is the pipeline.
interface msk_spook_inv_sbox_pipe_if #(
  parameter int D = 4
);
  localparam int RND_PER_AND = D * (D - 1) / 2;

  logic                     in_valid;
  logic                     in_ready;
  logic [4*D-1:0]           in;
  logic [4*RND_PER_AND-1:0] rnd;
  logic                     out_valid;
  logic                     out_ready;
  logic [4*D-1:0]           out;

  modport master (
    output in_valid, in, rnd, out_ready,
    input  in_ready, out_valid, out
  );

  modport slave (
    input  in_valid, in, rnd, out_ready,
    output in_ready, out_valid, out
  );
endinterface

// File: rtl/msk_spook_inv_sbox_pipe.sv
// D-share bitsliced inverse Clyde/Spook S-box: four DOM-indep AND stages under one global advance.
// Optional macro MSK_INV_SBOX_OUT_CLEAR_EN zeroes the output shares whenever out_valid is low.
module msk_spook_inv_sbox_pipe #(
  parameter int D = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  msk_spook_inv_sbox_pipe_if.slave bus
);
  localparam int RND_PER_AND = D * (D - 1) / 2;

  typedef logic [D-1:0]           sh_t;
  typedef logic [D-1:0][D-1:0]    terms_t;
  typedef logic [RND_PER_AND-1:0] rnd_t;

  // Row i holds every term that compresses into output share i; r_ij = r_ji in (i<j) order.
  function automatic terms_t dom_terms(input sh_t a, input sh_t b, input rnd_t r);
    terms_t t;
    int     k;
    t = '0;
    k = 0;
    for (int i = 0; i < D; i++) begin
      t[i][i] = a[i] & b[i];
      for (int j = i + 1; j < D; j++) begin
        t[i][j] = (a[i] & b[j]) ^ r[k];
        t[j][i] = (a[j] & b[i]) ^ r[k];
        k++;
      end
    end
    return t;
  endfunction

  function automatic sh_t dom_compress(input terms_t t);
    sh_t c;
    for (int i = 0; i < D; i++) c[i] = ^t[i];
    return c;
  endfunction

  logic   adv;
  logic   v1_q, v2_q, v3_q, v4_q, v1_d, v2_d, v3_d, v4_d;
  terms_t and1_q, and2_q, and3_q, and4_q, and1_d, and2_d, and3_d, and4_d;
  sh_t    y0_p1_q, y1_p1_q, y2_p1_q, y3_p1_q, y0_p1_d, y1_p1_d, y2_p1_d, y3_p1_d;
  sh_t    x3_p2_q, y0_p2_q, y1_p2_q, y3_p2_q, x3_p2_d, y0_p2_d, y1_p2_d, y3_p2_d;
  sh_t    x0_p3_q, x3_p3_q, y0_p3_q, y1_p3_q, x0_p3_d, x3_p3_d, y0_p3_d, y1_p3_d;
  sh_t    x0_p4_q, x1_p4_q, x3_p4_q, y1_p4_q, x0_p4_d, x1_p4_d, x3_p4_d, y1_p4_d;
  sh_t    y0_in, y1_in, y2_in, y3_in;
  sh_t    x3_c, x0_c, x1_c, x2_c;
  logic [4*D-1:0] out_raw;

  assign y0_in = bus.in[D*0 +: D];
  assign y1_in = bus.in[D*1 +: D];
  assign y2_in = bus.in[D*2 +: D];
  assign y3_in = bus.in[D*3 +: D];

  // Share-wise linear layer following each gadget's registers.
  assign x3_c = dom_compress(and1_q) ^ y2_p1_q;
  assign x0_c = dom_compress(and2_q) ^ y3_p2_q;
  assign x1_c = dom_compress(and3_q) ^ y0_p3_q;
  assign x2_c = dom_compress(and4_q) ^ y1_p4_q;

  assign adv = !v4_q || bus.out_ready;

  always_comb begin
    v1_d = v1_q;  v2_d = v2_q;  v3_d = v3_q;  v4_d = v4_q;
    and1_d = and1_q;  and2_d = and2_q;  and3_d = and3_q;  and4_d = and4_q;
    y0_p1_d = y0_p1_q;  y1_p1_d = y1_p1_q;  y2_p1_d = y2_p1_q;  y3_p1_d = y3_p1_q;
    x3_p2_d = x3_p2_q;  y0_p2_d = y0_p2_q;  y1_p2_d = y1_p2_q;  y3_p2_d = y3_p2_q;
    x0_p3_d = x0_p3_q;  x3_p3_d = x3_p3_q;  y0_p3_d = y0_p3_q;  y1_p3_d = y1_p3_q;
    x0_p4_d = x0_p4_q;  x1_p4_d = x1_p4_q;  x3_p4_d = x3_p4_q;  y1_p4_d = y1_p4_q;
    if (adv) begin
      // Stage 1: y0 & y1
      v1_d    = bus.in_valid;
      and1_d  = dom_terms(y0_in, y1_in, bus.rnd[RND_PER_AND*0 +: RND_PER_AND]);
      y0_p1_d = y0_in;
      y1_p1_d = y1_in;
      y2_p1_d = y2_in;
      y3_p1_d = y3_in;
      // Stage 2: y1 & x3
      v2_d    = v1_q;
      and2_d  = dom_terms(y1_p1_q, x3_c, bus.rnd[RND_PER_AND*1 +: RND_PER_AND]);
      x3_p2_d = x3_c;
      y0_p2_d = y0_p1_q;
      y1_p2_d = y1_p1_q;
      y3_p2_d = y3_p1_q;
      // Stage 3: x0 & x3
      v3_d    = v2_q;
      and3_d  = dom_terms(x0_c, x3_p2_q, bus.rnd[RND_PER_AND*2 +: RND_PER_AND]);
      x0_p3_d = x0_c;
      x3_p3_d = x3_p2_q;
      y0_p3_d = y0_p2_q;
      y1_p3_d = y1_p2_q;
      // Stage 4: x0 & x1
      v4_d    = v3_q;
      and4_d  = dom_terms(x0_p3_q, x1_c, bus.rnd[RND_PER_AND*3 +: RND_PER_AND]);
      x0_p4_d = x0_p3_q;
      x1_p4_d = x1_c;
      x3_p4_d = x3_p3_q;
      y1_p4_d = y1_p3_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;  v2_q <= 1'b0;  v3_q <= 1'b0;  v4_q <= 1'b0;
      and1_q <= '0;  and2_q <= '0;  and3_q <= '0;  and4_q <= '0;
      y0_p1_q <= '0;  y1_p1_q <= '0;  y2_p1_q <= '0;  y3_p1_q <= '0;
      x3_p2_q <= '0;  y0_p2_q <= '0;  y1_p2_q <= '0;  y3_p2_q <= '0;
      x0_p3_q <= '0;  x3_p3_q <= '0;  y0_p3_q <= '0;  y1_p3_q <= '0;
      x0_p4_q <= '0;  x1_p4_q <= '0;  x3_p4_q <= '0;  y1_p4_q <= '0;
    end else begin
      v1_q <= v1_d;  v2_q <= v2_d;  v3_q <= v3_d;  v4_q <= v4_d;
      and1_q <= and1_d;  and2_q <= and2_d;  and3_q <= and3_d;  and4_q <= and4_d;
      y0_p1_q <= y0_p1_d;  y1_p1_q <= y1_p1_d;  y2_p1_q <= y2_p1_d;  y3_p1_q <= y3_p1_d;
      x3_p2_q <= x3_p2_d;  y0_p2_q <= y0_p2_d;  y1_p2_q <= y1_p2_d;  y3_p2_q <= y3_p2_d;
      x0_p3_q <= x0_p3_d;  x3_p3_q <= x3_p3_d;  y0_p3_q <= y0_p3_d;  y1_p3_q <= y1_p3_d;
      x0_p4_q <= x0_p4_d;  x1_p4_q <= x1_p4_d;  x3_p4_q <= x3_p4_d;  y1_p4_q <= y1_p4_d;
    end
  end

  assign out_raw       = {x3_p4_q, x2_c, x1_p4_q, x0_p4_q};
  assign bus.in_ready  = adv;
  assign bus.out_valid = v4_q;

`ifdef MSK_INV_SBOX_OUT_CLEAR_EN
  assign bus.out = out_raw & {(4*D){v4_q}};
`else
  assign bus.out = out_raw;
`endif

endmodule

// File: tb/tb_msk_spook_inv_sbox_pipe.sv
// Randomized bench for msk_spook_inv_sbox_pipe (3 shares) with an in-order recombining scoreboard.
module tb_msk_spook_inv_sbox_pipe;
  localparam int D  = 3;
  localparam int W  = 4 * D;
  localparam int RW = 4 * (D * (D - 1) / 2);

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_err;
  logic [3:0] exp_q[$];
  int   out_cyc[$];
  logic mask_phase;
  logic [W-1:0] seen0, seen1;
  logic stall_prev;
  logic [W-1:0] prev_out;

  msk_spook_inv_sbox_pipe_if #(.D(D)) bus ();

  msk_spook_inv_sbox_pipe #(.D(D)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    logic [31:0] r32;
    r32 = $urandom;
    bus.rnd = r32[RW-1:0];
    forever begin
      @(posedge clk);
      #1;
      r32 = $urandom;
      bus.rnd = r32[RW-1:0];
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_err);
    $fatal(1, "watchdog");
  end

  // Inverse S-box straight from its bit equations; bit i of the nibble is y_i / x_i.
  function automatic logic [3:0] inv_sbox(input logic [3:0] y);
    logic x0, x1, x2, x3;
    x3 = (y[0] & y[1]) ^ y[2];
    x0 = (y[1] & x3) ^ y[3];
    x1 = (x0 & x3) ^ y[0];
    x2 = (x0 & x1) ^ y[1];
    return {x3, x2, x1, x0};
  endfunction

  function automatic logic [W-1:0] share(input logic [3:0] y);
    logic [W-1:0] s;
    logic p;
    for (int i = 0; i < 4; i++) begin
      p = y[i];
      for (int j = 0; j < D - 1; j++) begin
        s[D*i+j] = 1'($urandom);
        p ^= s[D*i+j];
      end
      s[D*i+D-1] = p;
    end
    return s;
  endfunction

  function automatic logic [3:0] recomb(input logic [W-1:0] s);
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = ^s[D*i +: D];
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Compare process: scoreboard, handshake rule and stall stability on every live cycle.
  initial begin
    stall_prev = 1'b0;
    prev_out   = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_prev = 1'b0;
      end else begin
        chk("in_ready_rule", bus.in_ready, !bus.out_valid || bus.out_ready);
        if (stall_prev) begin
          chk("stall_valid_hold", bus.out_valid, 1);
          chk("stall_out_hold", bus.out, prev_out);
        end
        if (bus.out_valid) begin
          if (exp_q.size() == 0) begin
            chk("out_valid_without_item", bus.out_valid, 0);
          end else begin
            chk("out_value", recomb(bus.out), inv_sbox(exp_q[0]));
            if (bus.out_ready) begin
              void'(exp_q.pop_front());
              out_cyc.push_back(cyc);
              if (mask_phase) begin
                seen1 |= bus.out;
                seen0 |= ~bus.out;
              end
            end
          end
        end
`ifdef MSK_INV_SBOX_OUT_CLEAR_EN
        if (!bus.out_valid) chk("out_cleared", bus.out, 0);
`endif
        stall_prev = bus.out_valid && !bus.out_ready;
        prev_out   = bus.out;
        if (bus.in_valid && bus.in_ready) exp_q.push_back(recomb(bus.in));
      end
    end
  end

  task automatic send(input logic [3:0] y, output int acc_cyc);
    int g;
    bus.in       = share(y);
    bus.in_valid = 1'b1;
    acc_cyc      = -1;
    g            = 0;
    while (acc_cyc < 0 && g < 50) begin
      @(negedge clk);
      if (bus.in_ready) acc_cyc = cyc;
      @(posedge clk);
      #1;
      g++;
    end
    bus.in_valid = 1'b0;
    chk("send_accepted", acc_cyc >= 0, 1);
  endtask

  task automatic drain();
    int g;
    g = 0;
    bus.out_ready = 1'b1;
    while (exp_q.size() != 0 && g < 200) begin
      @(posedge clk);
      #1;
      g++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic run_random(input int n_items, input bit fixed, input logic [3:0] fy);
    int  sent;
    int  g;
    bit  hand;
    sent = 0;
    g    = 0;
    bus.in_valid = 1'b0;
    while (sent < n_items && g < 20000) begin
      if (!bus.in_valid && $urandom_range(0, 3) != 0) begin
        bus.in_valid = 1'b1;
        bus.in       = share(fixed ? fy : 4'($urandom_range(0, 15)));
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      hand = bus.in_valid && bus.in_ready;
      @(posedge clk);
      #1;
      if (hand) begin
        sent++;
        bus.in_valid = 1'b0;
      end
      g++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    chk("random_items_sent", sent, n_items);
  endtask

  initial begin
    int c, found, n0;
    logic [3:0] v;
    logic [15:0] hit;
    n_checks = 0;
    n_err    = 0;
    mask_phase = 1'b0;
    seen0 = '0;
    seen1 = '0;
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in        = '0;
    bus.out_ready = 1'b1;

    repeat (3) @(negedge clk);
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_in_ready", bus.in_ready, 1);
    chk("reset_out", bus.out, 0);

    // Hand-derived points pinning the model, plus bijectivity of S^-1.
    chk("model_inv_6", inv_sbox(4'h6), 4'hB);
    chk("model_inv_0", inv_sbox(4'h0), 4'h0);
    chk("model_inv_f", inv_sbox(4'hF), 4'h3);
    hit = '0;
    for (int y = 0; y < 16; y++) hit[inv_sbox(4'(y))] = 1'b1;
    chk("model_bijective", hit, 16'hFFFF);

    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single item: y=(0,1,1,0) -> x=(1,1,0,1), out_valid 4 cycles after the accept cycle.
    send(4'h6, c);
    found = -1;
    v = '0;
    for (int i = 0; i < 10 && found < 0; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        found = cyc;
        v = recomb(bus.out);
      end
    end
    chk("single_latency", found - c, 4);
    chk("single_value", v, 4'hB);
    drain();

    // All 16 values back-to-back.
    n0 = out_cyc.size();
    for (int y = 0; y < 16; y++) send(4'(y), c);
    drain();
    chk("stream_count", out_cyc.size() - n0, 16);
    chk("stream_consecutive", out_cyc[n0+15] - out_cyc[n0], 15);

    // Backpressure with 4 items in flight.
    n0 = out_cyc.size();
    send(4'h7, c);
    send(4'h9, c);
    send(4'hC, c);
    send(4'h3, c);
    bus.out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready_low", bus.in_ready, 0);
      chk("bp_out_valid_high", bus.out_valid, 1);
    end
    @(posedge clk);
    #1;
    drain();
    chk("bp_count", out_cyc.size() - n0, 4);

    // Reset with 3 items in flight, the oldest stalled at the output.
    bus.out_ready = 1'b0;
    send(4'h1, c);
    send(4'h2, c);
    send(4'h4, c);
    @(posedge clk);
    #1;
    chk("pre_reset_out_valid", bus.out_valid, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_reset_out_valid", bus.out_valid, 0);
    chk("async_reset_out", bus.out, 0);
    chk("async_reset_in_ready", bus.in_ready, 1);
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    rst_n = 1'b1;
    n0 = out_cyc.size();
    send(4'h5, c);
    send(4'hA, c);
    drain();
    repeat (10) @(posedge clk);
    #1;
    chk("post_reset_count", out_cyc.size() - n0, 2);

    // Mask independence: fixed y, fresh sharings and randomness, random flow control.
    seen0 = '0;
    seen1 = '0;
    mask_phase = 1'b1;
    run_random(1000, 1'b1, 4'hD);
    drain();
    mask_phase = 1'b0;
    for (int b = 0; b < W; b++) chk($sformatf("share_bit_%0d_varies", b), seen0[b] & seen1[b], 1);

    // General random traffic.
    run_random(300, 1'b0, 4'h0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
